// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/bubble merge, flush sequencing, valid tracking, stall watchdog
// Optional perf counters built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int STAGES    = 5,
  parameter int ADDR_W    = 32,
  parameter int MAX_STALL = 256,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic              flush_req_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic [STAGES-1:0] stall_o,
  output logic [STAGES-1:0] bubble_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic [STAGES-1:0] valid_o,
  output logic              refilling_o,
  output logic              stall_timeout_o,
  input  logic              perf_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef enum logic [1:0] {RUN, FLUSH, REFILL} state_t;

  state_t            state, state_next;
  logic [STAGES-1:0] stall_raw;
  logic [STAGES-1:0] valid_d;
  logic              stall_acc;
  logic              flush_take;

  // A stall in stage k freezes every stage upstream of it.
  always_comb begin
    stall_acc = 1'b0;
    stall_raw = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stall_acc    = stall_acc | stallreq_i[k];
      stall_raw[k] = stall_acc;
    end
  end

  assign stall_o    = (rst && state != FLUSH) ? stall_raw : '0;
  assign bubble_o   = stall_o & ~{1'b1, stall_o[STAGES-1:1]};
  assign flush_take = flush_req_i && (state != FLUSH);

  always_comb begin
    valid_d = valid_o;
    if (flush_take) begin
      valid_d = '0;
    end else begin
      if (!stall_o[0]) valid_d[0] = 1'b1;
      for (int k = 1; k < STAGES; k++) begin
        if (!stall_o[k]) valid_d[k] = bubble_o[k-1] ? 1'b0 : valid_o[k-1];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush_take) state_next = FLUSH;
      FLUSH:   state_next = REFILL;
      REFILL: begin
        if (flush_take)                state_next = FLUSH;
        else if (valid_d[STAGES-1])    state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      valid_o  <= '0;
      new_pc_o <= '0;
    end else begin
      state   <= state_next;
      valid_o <= valid_d;
      if (flush_take) new_pc_o <= flush_pc_i;
    end
  end

  assign flush_o     = (state == FLUSH);
  assign refilling_o = (state == REFILL);

  generate
    if (MAX_STALL > 0) begin : g_wd
      localparam int RW = $clog2(MAX_STALL + 1);
      logic [RW-1:0] run_cnt;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          run_cnt         <= '0;
          stall_timeout_o <= 1'b0;
        end else if (!stall_o[0]) begin
          run_cnt <= '0;
        end else if (run_cnt != RW'(MAX_STALL)) begin
          run_cnt <= run_cnt + 1'b1;
          if (run_cnt == RW'(MAX_STALL - 1)) stall_timeout_o <= 1'b1;
        end
      end
    end else begin : g_no_wd
      assign stall_timeout_o = 1'b0;
    end
  endgenerate

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (perf_clr_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o[0] && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_take && !(&flush_cnt_o)) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr_i;
  assign stall_cnt_o     = '0;
  assign flush_cnt_o     = '0;
`endif

endmodule
